// File: rtl/chip8_timers.sv
// CHIP-8 delay and sound timers: a 60 Hz prescaler drives saturating decrements,
// and a square-wave tone drives the differential speaker pins while ST is non-zero.
module chip8_timers #(
   parameter int CLK_HZ  = 12_000_000,
   parameter int TICK_HZ = 60,
   parameter int TONE_HZ = 440
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       dt_we,
   input  logic       st_we,
   input  logic [7:0] wdata,
   output logic [7:0] dt_value,
   output logic [7:0] st_value,
   output logic       tick,
   input  logic       mute,
   output logic       sound_active,
   output logic       speaker,
   output logic       speaker_inv
);

   localparam int TICK_DIV = CLK_HZ / TICK_HZ;
   localparam int HALF     = CLK_HZ / (2 * TONE_HZ);
   localparam int PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int TW       = (HALF > 1) ? $clog2(HALF) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
   localparam logic [TW-1:0] TONE_LAST  = TW'(HALF - 1);

   if (TICK_DIV < 2 || HALF < 1) begin : g_badParams
      $error("chip8_timers: TICK_DIV must be >= 2 and HALF must be >= 1");
   end

   logic [PW-1:0] r_presc;
   logic [7:0]    r_dt;
   logic [7:0]    r_st;
   logic          r_sound;
   logic [TW-1:0] r_toneCnt;
   logic          r_phase;
   logic          r_spk;
   logic          r_spkInv;
   logic          w_tick;

   assign w_tick = (r_presc == PRESC_LAST);

   // Free-running prescaler; CPU writes deliberately have no effect on it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_presc <= '0;
      end else if (w_tick) begin
         r_presc <= '0;
      end else begin
         r_presc <= r_presc + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_dt <= 8'd0;
         r_st <= 8'd0;
      end else begin
         if (dt_we) begin
            r_dt <= wdata;
         end else if (w_tick && r_dt != 8'd0) begin
            r_dt <= r_dt - 8'd1;
         end
         if (st_we) begin
            r_st <= wdata;
         end else if (w_tick && r_st != 8'd0) begin
            r_st <= r_st - 8'd1;
         end
      end
   end

   // Tone state is held at zero while silent so each beep begins on a fresh half-period.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sound   <= 1'b0;
         r_toneCnt <= '0;
         r_phase   <= 1'b0;
         r_spk     <= 1'b0;
         r_spkInv  <= 1'b0;
      end else begin
         r_sound  <= (r_st != 8'd0);
         r_spk    <= r_sound & ~mute & r_phase;
         r_spkInv <= r_sound & ~mute & ~r_phase;
         if (!r_sound) begin
            r_toneCnt <= '0;
            r_phase   <= 1'b0;
         end else if (r_toneCnt == TONE_LAST) begin
            r_toneCnt <= '0;
            r_phase   <= ~r_phase;
         end else begin
            r_toneCnt <= r_toneCnt + 1'b1;
         end
      end
   end

   assign dt_value     = r_dt;
   assign st_value     = r_st;
   assign tick         = w_tick;
   assign sound_active = r_sound;
   assign speaker      = r_spk;
   assign speaker_inv  = r_spkInv;

endmodule
